// File: rtl/multibyte_adder_pkg.sv
// Shared types and constants for the byte-serial wide adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package multibyte_adder_pkg;

  // Width of one operand slice handled per cycle.
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } mba_state_t;

  // Byte index width; a single-byte adder still needs one bit for the index.
  function automatic int idx_width(input int nbytes);
    return (nbytes <= 1) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/Carry_Look_Ahead_Adder.sv
// 8-bit carry-look-ahead adder: sum = a + b + cin, cout = carry out of bit 7.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, outputs follow inputs.
module Carry_Look_Ahead_Adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carry chain from generate/propagate terms; synthesis flattens it into lookahead logic.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/multibyte_adder_seq.sv
// Byte-serial W-bit adder around one 8-bit CLA; optional signed overflow output under MBA_OVERFLOW_EN.
// Latency: result valid NBYTES cycles after the accept edge; one accept per NBYTES+2 cycles at best.
// Backpressure: result (sum/cout/ovf) holds in DONE until out_ready; in_ready is low outside IDLE.
module multibyte_adder_seq
  import multibyte_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BYTE_W*NBYTES-1:0]   a,
  input  logic [BYTE_W*NBYTES-1:0]   b,
  input  logic                       cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BYTE_W*NBYTES-1:0]   sum,
  output logic                       cout
`ifdef MBA_OVERFLOW_EN
  ,
  output logic                       ovf
`endif
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  mba_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              carry_q, carry_d;
`ifdef MBA_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  logic [BYTE_W-1:0] cla_a;
  logic [BYTE_W-1:0] cla_b;
  logic [BYTE_W-1:0] cla_sum;
  logic              cla_cout;

  // The latched operands are the only source for the CLA; port changes after accept are invisible.
  assign cla_a = a_q[BYTE_W*idx_q +: BYTE_W];
  assign cla_b = b_q[BYTE_W*idx_q +: BYTE_W];

  Carry_Look_Ahead_Adder u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Register all state with synchronous active-low reset; reset drops any in-flight add.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef MBA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef MBA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath: accept in IDLE, one byte per ADD cycle, hold the result in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef MBA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
`ifdef MBA_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[BYTE_W*idx_q +: BYTE_W] = cla_sum;
        carry_d = cla_cout;
        if (idx_q == LAST_IDX) begin
          // idx parks on the last byte rather than wrapping.
          state_d = DONE;
`ifdef MBA_OVERFLOW_EN
          // Carry into the MSB is recovered from the MSB sum bit, then compared with the carry out.
          ovf_d = (a_q[W-1] ^ b_q[W-1] ^ cla_sum[BYTE_W-1]) ^ cla_cout;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decode from registered state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
`ifdef MBA_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multibyte_adder_seq.sv
// Self-checking bench for multibyte_adder_seq at NBYTES=4 and NBYTES=1.
// Latency: checks out_valid arrives NBYTES edges after accept.
// Backpressure: exercises held results, blocked accepts and mid-op reset.
module tb_multibyte_adder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v4_in_valid, v4_in_ready, v4_out_valid, v4_out_ready, v4_cin, v4_cout;
  logic [31:0] v4_a, v4_b, v4_sum;
  logic        v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready, v1_cin, v1_cout;
  logic [7:0]  v1_a, v1_b, v1_sum;
`ifdef MBA_OVERFLOW_EN
  logic        v4_ovf, v1_ovf;
`endif

  multibyte_adder_seq #(.NBYTES(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v4_in_valid),
    .in_ready  (v4_in_ready),
    .a         (v4_a),
    .b         (v4_b),
    .cin       (v4_cin),
    .out_valid (v4_out_valid),
    .out_ready (v4_out_ready),
    .sum       (v4_sum),
    .cout      (v4_cout)
`ifdef MBA_OVERFLOW_EN
    ,
    .ovf       (v4_ovf)
`endif
  );

  multibyte_adder_seq #(.NBYTES(1)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1_in_valid),
    .in_ready  (v1_in_ready),
    .a         (v1_a),
    .b         (v1_b),
    .cin       (v1_cin),
    .out_valid (v1_out_valid),
    .out_ready (v1_out_ready),
    .sum       (v1_sum),
    .cout      (v1_cout)
`ifdef MBA_OVERFLOW_EN
    ,
    .ovf       (v1_ovf)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic [31:0] es, input logic ec, input logic eo, input string tag);
    int n;
    n = 0;
    while (!v4_in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_in_ready"}, 32'(v4_in_ready), 32'd1);
    v4_a = a; v4_b = b; v4_cin = cin; v4_in_valid = 1'b1;
    @(posedge clk); #1;
    v4_in_valid = 1'b0;
    v4_a = ~a; v4_b = ~b; v4_cin = ~cin;
    n = 0;
    while (!v4_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_sum"}, v4_sum, es);
    check({tag, "_cout"}, 32'(v4_cout), 32'(ec));
`ifdef MBA_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(v4_ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: undefined ovf expectation in %s", tag);
`endif
    check({tag, "_busy_in_ready"}, 32'(v4_in_ready), 32'd0);
    v4_out_ready = 1'b1;
    @(posedge clk); #1;
    v4_out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(v4_out_valid), 32'd0);
  endtask

  task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [7:0] es, input logic ec, input logic eo, input string tag);
    int n;
    n = 0;
    while (!v1_in_ready && n < 20) begin @(posedge clk); #1; n++; end
    v1_a = a; v1_b = b; v1_cin = cin; v1_in_valid = 1'b1;
    @(posedge clk); #1;
    v1_in_valid = 1'b0;
    v1_a = ~a; v1_b = ~b; v1_cin = ~cin;
    n = 0;
    while (!v1_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_latency"}, 32'(n), 32'd1);
    check({tag, "_sum"}, 32'(v1_sum), 32'(es));
    check({tag, "_cout"}, 32'(v1_cout), 32'(ec));
`ifdef MBA_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(v1_ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: undefined ovf expectation in %s", tag);
`endif
    v1_out_ready = 1'b1;
    @(posedge clk); #1;
    v1_out_ready = 1'b0;
    check({tag, "_in_ready_after"}, 32'(v1_in_ready), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    logic seen;

    vecs[0] = '{a: 32'd150,        b: 32'd32,         cin: 1'b1, sum: 32'd183,        cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'h0000_0001,  cin: 1'b0, sum: 32'h0000_0000,  cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 32'h7FFF_FFFF,  b: 32'h0000_0001,  cin: 1'b0, sum: 32'h8000_0000,  cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  cin: 1'b0, sum: 32'h0000_0000,  cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 32'h1234_5678,  b: 32'h9ABC_DEF0,  cin: 1'b0, sum: 32'hACF1_3568,  cout: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  cin: 1'b1, sum: 32'hFFFF_FFFF,  cout: 1'b1, ovf: 1'b0};
    vecs[6] = '{a: 32'h00FF_00FF,  b: 32'h0001_0001,  cin: 1'b0, sum: 32'h0100_0100,  cout: 1'b0, ovf: 1'b0};

    rst_n = 1'b0;
    v4_in_valid = 1'b0; v4_out_ready = 1'b0; v4_a = '0; v4_b = '0; v4_cin = 1'b0;
    v1_in_valid = 1'b0; v1_out_ready = 1'b0; v1_a = '0; v1_b = '0; v1_cin = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst4_in_ready", 32'(v4_in_ready), 32'd1);
    check("rst4_out_valid", 32'(v4_out_valid), 32'd0);
    check("rst4_sum", v4_sum, 32'd0);
    check("rst4_cout", 32'(v4_cout), 32'd0);
    check("rst1_in_ready", 32'(v1_in_ready), 32'd1);
    check("rst1_out_valid", 32'(v1_out_valid), 32'd0);
    check("rst1_sum", 32'(v1_sum), 32'd0);
`ifdef MBA_OVERFLOW_EN
    check("rst4_ovf", 32'(v4_ovf), 32'd0);
    check("rst1_ovf", 32'(v1_ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 7; i++) begin
      run4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
           $sformatf("vec%0d", i));
    end

    // Backpressure with a competing request held on the input side
    v4_a = 32'h1111_1111; v4_b = 32'h2222_2222; v4_cin = 1'b0; v4_in_valid = 1'b1;
    @(posedge clk); #1;
    v4_a = 32'd1; v4_b = 32'd2; v4_cin = 1'b0;
    n = 0;
    while (!v4_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_latency", 32'(n), 32'd4);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_sum_c%0d", c), v4_sum, 32'h3333_3333);
      check($sformatf("bp_cout_c%0d", c), 32'(v4_cout), 32'd0);
      check($sformatf("bp_in_ready_c%0d", c), 32'(v4_in_ready), 32'd0);
      check($sformatf("bp_out_valid_c%0d", c), 32'(v4_out_valid), 32'd1);
    end
    v4_out_ready = 1'b1;
    @(posedge clk); #1;
    v4_out_ready = 1'b0;
    check("bp_release_in_ready", 32'(v4_in_ready), 32'd1);
    check("bp_release_out_valid", 32'(v4_out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp_new_accept", 32'(v4_in_ready), 32'd0);
    v4_in_valid = 1'b0;
    n = 0;
    while (!v4_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_new_latency", 32'(n), 32'd4);
    check("bp_new_sum", v4_sum, 32'd3);
    v4_out_ready = 1'b1;
    @(posedge clk); #1;
    v4_out_ready = 1'b0;

    // Reset during the second ADD cycle
    v4_a = 32'h0101_0101; v4_b = 32'h0101_0101; v4_cin = 1'b1; v4_in_valid = 1'b1;
    @(posedge clk); #1;
    v4_in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_in_ready", 32'(v4_in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(v4_out_valid), 32'd0);
    check("mid_rst_sum", v4_sum, 32'd0);
    check("mid_rst_cout", 32'(v4_cout), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (v4_out_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    run4(32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0, "post_rst");

    // Single-byte instance
    run1(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, "nb1_a");
    run1(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, "nb1_b");
    run1(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, "nb1_c");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
